// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters,
// with per-requester lock ownership bounded by a MAX_LOCK timeout.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          R0_REQ,
  input  logic          R0_LOCK,
  input  logic          R0_WR,
  input  logic [AW-1:0] R0_ADDR,
  input  logic [DW-1:0] R0_WDATA,
  output logic          R0_GNT,
  output logic          R0_RVALID,
  output logic [DW-1:0] R0_RDATA,
  input  logic          R1_REQ,
  input  logic          R1_LOCK,
  input  logic          R1_WR,
  input  logic [AW-1:0] R1_ADDR,
  input  logic [DW-1:0] R1_WDATA,
  output logic          R1_GNT,
  output logic          R1_RVALID,
  output logic [DW-1:0] R1_RDATA,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA
);

  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          pri_q, pri_d;
  logic [LW-1:0] lcnt_q, lcnt_d, lcnt_inc_s;
  logic          rv0_q, rv0_d, rv1_q, rv1_d;
  logic          gnt0_s, gnt1_s, lock_s;

  // Grant selection and next ownership / priority / lock count
  always_comb begin
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    lock_s     = 1'b0;
    state_d    = state_q;
    pri_d      = pri_q;
    lcnt_d     = lcnt_q;
    lcnt_inc_s = lcnt_q + LW'(1);
    case (state_q)
      IDLE: begin
        if (R0_REQ && R1_REQ) begin
          gnt0_s = ~pri_q;
          gnt1_s = pri_q;
        end else begin
          gnt0_s = R0_REQ;
          gnt1_s = R1_REQ;
        end
      end
      OWN0: begin
        if (R0_REQ) begin
          gnt0_s = 1'b1;
        end else begin
          state_d = IDLE;
          pri_d   = 1'b1;
          lcnt_d  = '0;
        end
      end
      OWN1: begin
        if (R1_REQ) begin
          gnt1_s = 1'b1;
        end else begin
          state_d = IDLE;
          pri_d   = 1'b0;
          lcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        lcnt_d  = '0;
      end
    endcase
    // A granted transaction decides whether ownership persists or times out
    if (gnt0_s || gnt1_s) begin
      lock_s = gnt0_s ? R0_LOCK : R1_LOCK;
      if (lock_s && (lcnt_inc_s < MAX_L)) begin
        state_d = gnt0_s ? OWN0 : OWN1;
        lcnt_d  = lcnt_inc_s;
      end else begin
        state_d = IDLE;
        lcnt_d  = '0;
        pri_d   = gnt0_s;
      end
    end else begin
      lock_s = 1'b0;
    end
    rv0_d = gnt0_s & ~R0_WR;
    rv1_d = gnt1_s & ~R1_WR;
  end

  // Output steering; everything is forced quiet while Reset is high
  always_comb begin
    R0_GNT    = gnt0_s & ~Reset;
    R1_GNT    = gnt1_s & ~Reset;
    R0_RVALID = rv0_q & ~Reset;
    R1_RVALID = rv1_q & ~Reset;
    R0_RDATA  = R0_RVALID ? MEM_RDATA : {DW{1'b0}};
    R1_RDATA  = R1_RVALID ? MEM_RDATA : {DW{1'b0}};
    if (R0_GNT) begin
      MEM_ADDR  = R0_ADDR;
      MEM_WDATA = R0_WDATA;
      MEM_WR    = R0_WR;
    end else if (R1_GNT) begin
      MEM_ADDR  = R1_ADDR;
      MEM_WDATA = R1_WDATA;
      MEM_WR    = R1_WR;
    end else begin
      MEM_ADDR  = {AW{1'b0}};
      MEM_WDATA = {DW{1'b0}};
      MEM_WR    = 1'b0;
    end
  end

  // State, priority, lock counter and read-return registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      pri_q   <= 1'b0;
      lcnt_q  <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      lcnt_q  <= lcnt_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (8-bit address, 16-bit data) between two requesters.
- Requester 0 is the Control_Unit load/store path. Requester 1 is the program/debug loader.
- Arbitration is round-robin per transaction.
- A lock lets one requester hold the memory for multi-cycle sequences such as the two-cycle load, bounded by a timeout.
- Sits between the requesters and the data memory's D_ADDR/D_WR/data pins.

Parameters:
AW, 8, memory address width
DW, 16, memory data width
MAX_LOCK, 4, max consecutive granted cycles one requester may hold a lock (>=1)

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
R0_REQ  in  1  requester 0 wants a transaction this cycle
R0_LOCK  in  1  requester 0 wants to keep ownership after this transaction
R0_WR  in  1  1=write, 0=read
R0_ADDR  in  AW  address
R0_WDATA  in  DW  write data
R0_GNT  out  1  transaction accepted this cycle (combinational)
R0_RVALID  out  1  read data valid (registered, one cycle after a granted read)
R0_RDATA  out  DW  read data, 0 when R0_RVALID low
R1_*  (same seven ports for requester 1)
MEM_ADDR  out  AW  to data memory
MEM_WR  out  1  data memory write enable
MEM_WDATA  out  DW  to data memory
MEM_RDATA  in  DW  from data memory, valid the cycle after the address is presented

Behaviour:
- Reset (sampled at the edge):
  - state=IDLE, PRI=0, LCNT=0, both RVALID=0.
  - While Reset is high: GNT=0, MEM_WR=0, MEM_ADDR=0, MEM_WDATA=0.
  - Reset mid-lock abandons the lock. A read granted in the cycle before Reset produces no RVALID.
- States: IDLE, OWN0, OWN1. PRI (1 bit) selects which requester wins a tie in IDLE.
- IDLE:
  - Only one REQ high: that requester is granted.
  - Both high: requester PRI is granted.
  - Neither: no grant, outputs zero.
- OWNk:
  - Only requester k can be granted. The other's REQ is ignored and its GNT stays 0; the other requester must hold its request.
  - R_k REQ low in OWNk: no grant that cycle, next state IDLE, PRI=other, LCNT=0.
- On a grant to k:
  - MEM_ADDR=Rk_ADDR, MEM_WDATA=Rk_WDATA, MEM_WR=Rk_WR.
  - PRI <= not k, unless the next state is OWNk.
  - Next state is OWNk if Rk_LOCK=1 and LCNT+1 < MAX_LOCK; otherwise IDLE.
  - LCNT <= LCNT+1 when entering or staying in OWNk, else 0.
- Timeout: after MAX_LOCK consecutive locked grants the block returns to IDLE with PRI=other, even if LOCK is still high. The other requester, if waiting, wins the next cycle.
- Read return: if a read was granted to k at edge N, Rk_RVALID=1 during cycle N+1 and Rk_RDATA=MEM_RDATA. Back-to-back reads give RVALID on consecutive cycles.
- Writes: no RVALID. Memory writes at the grant edge.
- MEM_WR is never high without a GNT. At most one GNT is high per cycle.
- LCNT width is clog2(MAX_LOCK+1). MAX_LOCK=1 means a lock never persists beyond one transaction.

Test Plan:
- Arbitration and read return:
  - Stimulus: release Reset; both REQ=1 read, R0_ADDR=0x10, R1_ADDR=0x20, mem[0x10]=0xAAAA, mem[0x20]=0x5555.
  - Required: cycle 1 R0_GNT=1, MEM_ADDR=0x10. Cycle 2 R1_GNT=1, MEM_ADDR=0x20, R0_RVALID=1, R0_RDATA=0xAAAA. Cycle 3 R1_RVALID=1, R1_RDATA=0x5555.
- Lock held across a two-cycle load:
  - Stimulus: R0 read with LOCK=1 for 2 cycles then LOCK=0, while R1 requests a write of 0x1234 to 0x05 throughout.
  - Required: R0_GNT for 3 consecutive cycles, R1_GNT=0 during them. R1 is granted in cycle 4 and mem[0x05]=0x1234 afterwards.
- Lock timeout:
  - Stimulus: MAX_LOCK=4; R0 holds REQ=LOCK=1 continuously; R1_REQ=1.
  - Required: R0 granted 4 cycles, R1 granted cycle 5, R0 granted cycle 6.
- Release by dropping REQ:
  - Stimulus: R1 locks, then drops REQ while R0 is requesting.
  - Required: one cycle with no GNT (state IDLE), then R0_GNT=1.
- Reset mid-operation:
  - Stimulus: Reset asserted the cycle after an R0 read grant while in OWN0.
  - Required: R0_RVALID=0, all GNT=0, MEM_WR=0. After Reset drops, simultaneous requests grant R0 first (PRI=0).
- Single-requester streaming:
  - Stimulus: R1 alone issues writes to 0x00..0x03, then reads them back.
  - Required: grant every cycle, no bubbles, reads return the written values one cycle later.
